// File: rtl/apb_pkg.sv
// Shared APB constants and types for the audioport control bus.
package apb_pkg;

    localparam int APB_DATA_W = 32;
    localparam int APB_ADDR_W = 32;

    localparam logic [APB_ADDR_W-1:0] DUT_START_ADDRESS   = 32'h8c000000;
    localparam logic [APB_ADDR_W-1:0] DUT_END_ADDRESS     = 32'h8c00001f;
    localparam int                    APB_MAX_WAIT_STATES = 0;

    typedef enum logic [1:0] {
        APB_IDLE,
        APB_SETUP,
        APB_ACCESS
    } apb_phase_t;

endpackage

// File: rtl/apb_phase_fsm.sv
// APB phase tracker: flags the cycle that completes a transfer and hands on the transfer fields.
// Define APB_PROTOCOL_CHECK_EN to capture SETUP-phase fields and raise a sticky protocol error flag.
module apb_phase_fsm
    import apb_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_psel,
    input  logic                  i_penable,
    input  logic                  i_pwrite,
    input  logic [APB_ADDR_W-1:0] i_paddr,
    input  logic [APB_DATA_W-1:0] i_pwdata,
    output logic                  o_access,
    output logic                  o_pwrite,
    output logic [APB_ADDR_W-1:0] o_paddr,
    output logic [APB_DATA_W-1:0] o_pwdata,
    output logic                  o_suppress,
    output logic                  o_protErr
);

    apb_phase_t r_state;
    apb_phase_t w_next;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= APB_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // w_next is also the phase of the current bus cycle, so ACCESS completes with zero wait states.
    always_comb begin
        w_next = APB_IDLE;
        unique case (r_state)
            APB_IDLE: begin
                if (i_psel && !i_penable) w_next = APB_SETUP;
            end
            APB_SETUP: begin
                if (i_psel && i_penable) w_next = APB_ACCESS;
                else if (i_psel)         w_next = APB_SETUP;
            end
            APB_ACCESS: begin
                if (i_psel && !i_penable) w_next = APB_SETUP;
            end
            default: w_next = APB_IDLE;
        endcase
    end

    assign o_access = (w_next == APB_ACCESS);

`ifdef APB_PROTOCOL_CHECK_EN
    logic [APB_ADDR_W-1:0] r_capAddr;
    logic [APB_DATA_W-1:0] r_capWdata;
    logic                  r_capWrite;
    logic                  r_protErr;
    logic                  w_mismatch;
    logic                  w_violation;

    assign w_mismatch  = o_access && ((i_paddr != r_capAddr) || (i_pwrite != r_capWrite) ||
                                      (i_pwdata != r_capWdata));
    assign w_violation = (i_penable && (r_state != APB_SETUP)) || w_mismatch ||
                         ((r_state == APB_SETUP) && !i_psel);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_capAddr  <= '0;
            r_capWdata <= '0;
            r_capWrite <= 1'b0;
            r_protErr  <= 1'b0;
        end else begin
            if (w_next == APB_SETUP) begin
                r_capAddr  <= i_paddr;
                r_capWdata <= i_pwdata;
                r_capWrite <= i_pwrite;
            end
            if (w_violation) r_protErr <= 1'b1;
        end
    end

    assign o_pwrite   = r_capWrite;
    assign o_paddr    = r_capAddr;
    assign o_pwdata   = r_capWdata;
    assign o_suppress = w_mismatch;
    assign o_protErr  = r_protErr;
`else
    assign o_pwrite   = i_pwrite;
    assign o_paddr    = i_paddr;
    assign o_pwdata   = i_pwdata;
    assign o_suppress = 1'b0;
    assign o_protErr  = 1'b0;
`endif

endmodule

// File: rtl/apb_completer.sv
// APB completer for the audioport control bus: address decode, control register bank, read/status path.
// Define APB_PROTOCOL_CHECK_EN to enable the protocol checker inside apb_phase_fsm.
module apb_completer
    import apb_pkg::*;
#(
    parameter logic [APB_ADDR_W-1:0] BASE_ADDR     = DUT_START_ADDRESS,
    parameter int                    REG_COUNT     = 8,
    parameter logic [APB_DATA_W-1:0] REG_RESET_VAL = 32'h0
)(
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             PSEL,
    input  logic                             PENABLE,
    input  logic                             PWRITE,
    input  logic [APB_ADDR_W-1:0]            PADDR,
    input  logic [APB_DATA_W-1:0]            PWDATA,
    output logic [APB_DATA_W-1:0]            PRDATA,
    output logic                             PREADY,
    output logic                             PSLVERR,
    output logic [APB_DATA_W*REG_COUNT-1:0]  regs_out,
    output logic [REG_COUNT-1:0]             wr_pulse,
    input  logic [APB_DATA_W-1:0]            status_in,
    output logic                             prot_err
);

    localparam int                    IDX_W      = $clog2(REG_COUNT);
    localparam logic [APB_ADDR_W-1:0] SPAN       = APB_ADDR_W'(4 * REG_COUNT);
    localparam logic [IDX_W-1:0]      STATUS_IDX = IDX_W'(REG_COUNT - 1);

    logic                  w_access;
    logic                  w_pwrite;
    logic [APB_ADDR_W-1:0] w_paddr;
    logic [APB_DATA_W-1:0] w_pwdata;
    logic                  w_suppress;

    apb_phase_fsm u_phaseFsm (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_psel     (PSEL),
        .i_penable  (PENABLE),
        .i_pwrite   (PWRITE),
        .i_paddr    (PADDR),
        .i_pwdata   (PWDATA),
        .o_access   (w_access),
        .o_pwrite   (w_pwrite),
        .o_paddr    (w_paddr),
        .o_pwdata   (w_pwdata),
        .o_suppress (w_suppress),
        .o_protErr  (prot_err)
    );

    // Unsigned subtract wraps addresses below BASE_ADDR to large offsets, so one compare covers both bounds.
    logic [APB_ADDR_W-1:0] w_offset;
    logic                  w_hit;
    logic [IDX_W-1:0]      w_idx;
    logic                  w_aligned;
    logic                  w_isStatus;
    logic                  w_legal;
    logic                  w_wrEn;
    logic                  w_slvErr;
    logic [APB_DATA_W-1:0] w_rdData;

    assign w_offset   = w_paddr - BASE_ADDR;
    assign w_hit      = (w_offset < SPAN);
    assign w_idx      = w_offset[IDX_W+1:2];
    assign w_aligned  = (w_paddr[1:0] == 2'b00);
    assign w_isStatus = (w_idx == STATUS_IDX);
    assign w_legal    = w_access && w_hit;
    assign w_wrEn     = w_legal && w_pwrite && w_aligned && !w_isStatus && !w_suppress;
    assign w_slvErr   = w_legal && (!w_aligned || (w_pwrite && w_isStatus));

    logic [APB_DATA_W-1:0] r_regs [REG_COUNT];
    logic [REG_COUNT-1:0]  r_wrPulse;

    always_comb begin
        w_rdData = '0;
        if (w_legal && !w_pwrite && w_aligned) begin
            w_rdData = w_isStatus ? status_in : r_regs[w_idx];
        end
    end

    // The STATUS slot is never written, so it holds REG_RESET_VAL and folds away in synthesis.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_COUNT; i++) r_regs[i] <= REG_RESET_VAL;
            r_wrPulse <= '0;
        end else begin
            r_wrPulse <= '0;
            if (w_wrEn) begin
                r_regs[w_idx]    <= w_pwdata;
                r_wrPulse[w_idx] <= 1'b1;
            end
        end
    end

    for (genvar g = 0; g < REG_COUNT; g++) begin : g_regsOut
        assign regs_out[APB_DATA_W*g +: APB_DATA_W] = r_regs[g];
    end

    assign wr_pulse = r_wrPulse;
    assign PRDATA   = rst_n ? w_rdData : '0;
    assign PSLVERR  = rst_n && w_slvErr;
    assign PREADY   = 1'b1;

endmodule

// File: tb/tb_apb_completer.sv
// Bench for apb_completer: directed vector table, hand-written multi-cycle sequences and
// randomized transfers scored against a register-array model of the bus map.
module tb_apb_completer;

    localparam logic [31:0] BASE = 32'h8c000000;
`ifdef APB_PROTOCOL_CHECK_EN
    localparam logic CHECK_EN = 1'b1;
`else
    localparam logic CHECK_EN = 1'b0;
`endif

    logic         clk      = 1'b0;
    logic         rst_n    = 1'b0;
    logic         psel     = 1'b0;
    logic         penable  = 1'b0;
    logic         pwrite   = 1'b0;
    logic [31:0]  paddr    = 32'h0;
    logic [31:0]  pwdata   = 32'h0;
    logic [31:0]  statusIn = 32'h0;
    logic [31:0]  prdata;
    logic         pready;
    logic         pslverr;
    logic [255:0] regsOut;
    logic [7:0]   wrPulse;
    logic         protErr;

    int total = 0;
    int bad   = 0;

    logic [31:0] model [8];

    typedef struct {
        logic        psel;
        logic        penable;
        logic        pwrite;
        logic [31:0] paddr;
        logic [31:0] pwdata;
        logic [31:0] expRdata;
        logic        expErr;
        logic [7:0]  expPulse;
        logic [31:0] expReg1;
    } vec_t;

    always #5 clk = ~clk;

    apb_completer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .PSEL      (psel),
        .PENABLE   (penable),
        .PWRITE    (pwrite),
        .PADDR     (paddr),
        .PWDATA    (pwdata),
        .PRDATA    (prdata),
        .PREADY    (pready),
        .PSLVERR   (pslverr),
        .regs_out  (regsOut),
        .wr_pulse  (wrPulse),
        .status_in (statusIn),
        .prot_err  (protErr)
    );

    // Inputs change 1 time unit after the rising edge; outputs are observed on the falling edge.
    task automatic applyStimulus(input logic r, input logic s, input logic e, input logic w,
                                 input logic [31:0] a, input logic [31:0] d);
        @(posedge clk);
        #1;
        rst_n   = r;
        psel    = s;
        penable = e;
        pwrite  = w;
        paddr   = a;
        pwdata  = d;
        @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] packModel();
        logic [255:0] v;
        v = '0;
        for (int i = 0; i < 8; i++) v[32*i +: 32] = model[i];
        return v;
    endfunction

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: time limit reached before completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t        vecs [24];
        logic [7:0]  expPulse;
        logic        isWrite;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] off;
        logic [31:0] expRd;
        logic        hit;
        logic        aligned;
        logic        expErr;
        int          idx;
        int          sel;

        vecs[0]  = '{1'b1, 1'b0, 1'b1, BASE + 32'h04,  32'hDEADBEEF, 32'h0,        1'b0, 8'h00, 32'h0};
        vecs[1]  = '{1'b1, 1'b1, 1'b1, BASE + 32'h04,  32'hDEADBEEF, 32'h0,        1'b0, 8'h00, 32'h0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 32'h0,          32'h0,        32'h0,        1'b0, 8'h02, 32'hDEADBEEF};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, BASE + 32'h04,  32'h0,        32'h0,        1'b0, 8'h00, 32'hDEADBEEF};
        vecs[4]  = '{1'b1, 1'b1, 1'b0, BASE + 32'h04,  32'h0,        32'hDEADBEEF, 1'b0, 8'h00, 32'hDEADBEEF};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, BASE + 32'h1C,  32'h0,        32'h0,        1'b0, 8'h00, 32'hDEADBEEF};
        vecs[6]  = '{1'b1, 1'b1, 1'b0, BASE + 32'h1C,  32'h0,        32'h5A5A0001, 1'b0, 8'h00, 32'hDEADBEEF};
        vecs[7]  = '{1'b1, 1'b0, 1'b1, BASE + 32'h1C,  32'h11111111, 32'h0,        1'b0, 8'h00, 32'hDEADBEEF};
        vecs[8]  = '{1'b1, 1'b1, 1'b1, BASE + 32'h1C,  32'h11111111, 32'h0,        1'b1, 8'h00, 32'hDEADBEEF};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 32'h0,          32'h0,        32'h0,        1'b0, 8'h00, 32'hDEADBEEF};
        vecs[10] = '{1'b1, 1'b0, 1'b1, BASE + 32'h06,  32'h22222222, 32'h0,        1'b0, 8'h00, 32'hDEADBEEF};
        vecs[11] = '{1'b1, 1'b1, 1'b1, BASE + 32'h06,  32'h22222222, 32'h0,        1'b1, 8'h00, 32'hDEADBEEF};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 32'h0,          32'h0,        32'h0,        1'b0, 8'h00, 32'hDEADBEEF};
        vecs[13] = '{1'b1, 1'b0, 1'b1, BASE + 32'h400, 32'h33333333, 32'h0,        1'b0, 8'h00, 32'hDEADBEEF};
        vecs[14] = '{1'b1, 1'b1, 1'b1, BASE + 32'h400, 32'h33333333, 32'h0,        1'b0, 8'h00, 32'hDEADBEEF};
        vecs[15] = '{1'b0, 1'b0, 1'b0, 32'h0,          32'h0,        32'h0,        1'b0, 8'h00, 32'hDEADBEEF};
        vecs[16] = '{1'b1, 1'b0, 1'b0, BASE + 32'h400, 32'h0,        32'h0,        1'b0, 8'h00, 32'hDEADBEEF};
        vecs[17] = '{1'b1, 1'b1, 1'b0, BASE + 32'h400, 32'h0,        32'h0,        1'b0, 8'h00, 32'hDEADBEEF};
        vecs[18] = '{1'b1, 1'b0, 1'b0, BASE + 32'h04,  32'h0,        32'h0,        1'b0, 8'h00, 32'hDEADBEEF};
        vecs[19] = '{1'b1, 1'b1, 1'b0, BASE + 32'h04,  32'h0,        32'hDEADBEEF, 1'b0, 8'h00, 32'hDEADBEEF};
        vecs[20] = '{1'b1, 1'b1, 1'b1, BASE + 32'h08,  32'h44444444, 32'h0,        1'b0, 8'h00, 32'hDEADBEEF};
        vecs[21] = '{1'b0, 1'b0, 1'b0, 32'h0,          32'h0,        32'h0,        1'b0, 8'h00, 32'hDEADBEEF};
        vecs[22] = '{1'b1, 1'b1, 1'b0, BASE + 32'h05,  32'h0,        32'h0,        1'b0, 8'h00, 32'hDEADBEEF};
        vecs[23] = '{1'b0, 1'b0, 1'b0, 32'h0,          32'h0,        32'h0,        1'b0, 8'h00, 32'hDEADBEEF};

        $display("[TB] reset");
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
            checkOutput($sformatf("reset%0d regs_out", i), regsOut, 256'h0);
            checkOutput($sformatf("reset%0d wr_pulse", i), 256'(wrPulse), 256'h0);
            checkOutput($sformatf("reset%0d PRDATA", i), 256'(prdata), 256'h0);
            checkOutput($sformatf("reset%0d PSLVERR", i), 256'(pslverr), 256'h0);
            checkOutput($sformatf("reset%0d prot_err", i), 256'(protErr), 256'h0);
            checkOutput($sformatf("reset%0d PREADY", i), 256'(pready), 256'h1);
        end

        $display("[TB] vector table");
        statusIn = 32'h5A5A0001;
        for (int i = 0; i < 24; i++) begin
            applyStimulus(1'b1, vecs[i].psel, vecs[i].penable, vecs[i].pwrite, vecs[i].paddr, vecs[i].pwdata);
            checkOutput($sformatf("vec%0d PRDATA", i), 256'(prdata), 256'(vecs[i].expRdata));
            checkOutput($sformatf("vec%0d PSLVERR", i), 256'(pslverr), 256'(vecs[i].expErr));
            checkOutput($sformatf("vec%0d wr_pulse", i), 256'(wrPulse), 256'(vecs[i].expPulse));
            checkOutput($sformatf("vec%0d reg1", i), 256'(regsOut[63:32]), 256'(vecs[i].expReg1));
            checkOutput($sformatf("vec%0d PREADY", i), 256'(pready), 256'h1);
        end
        checkOutput("table regs_out", regsOut, {192'h0, 32'hDEADBEEF, 32'h0});

        $display("[TB] reset during transfer");
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, BASE + 32'h04, 32'h0);
        checkOutput("abort setup PRDATA", 256'(prdata), 256'h0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, BASE + 32'h04, 32'h0);
        checkOutput("abort read PRDATA", 256'(prdata), 256'h0);
        checkOutput("abort read PSLVERR", 256'(pslverr), 256'h0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, BASE + 32'h06, 32'h77777777);
        checkOutput("abort regs cleared", regsOut, 256'h0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, BASE + 32'h06, 32'h77777777);
        checkOutput("abort write PSLVERR", 256'(pslverr), 256'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        checkOutput("abort wr_pulse", 256'(wrPulse), 256'h0);
        checkOutput("abort regs_out", regsOut, 256'h0);
        checkOutput("abort prot_err", 256'(protErr), 256'h0);

        $display("[TB] back-to-back writes");
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, BASE, 32'h1);
        checkOutput("b2b setup1 wr_pulse", 256'(wrPulse), 256'h0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, BASE, 32'h1);
        checkOutput("b2b access1 PSLVERR", 256'(pslverr), 256'h0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, BASE, 32'h2);
        checkOutput("b2b setup2 wr_pulse", 256'(wrPulse), 256'h01);
        checkOutput("b2b setup2 reg0", 256'(regsOut[31:0]), 256'h1);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, BASE, 32'h2);
        checkOutput("b2b access2 wr_pulse", 256'(wrPulse), 256'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        checkOutput("b2b after wr_pulse", 256'(wrPulse), 256'h01);
        checkOutput("b2b after reg0", 256'(regsOut[31:0]), 256'h2);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        checkOutput("b2b idle wr_pulse", 256'(wrPulse), 256'h0);

        $display("[TB] protocol checks");
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, BASE + 32'h08, 32'hAAAA5555);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, BASE + 32'h0C, 32'hAAAA5555);
        checkOutput("paddr change PSLVERR", 256'(pslverr), 256'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        checkOutput("paddr change prot_err", 256'(protErr), 256'(CHECK_EN));
        checkOutput("paddr change wr_pulse", 256'(wrPulse), CHECK_EN ? 256'h0 : 256'h08);
        checkOutput("paddr change reg3", 256'(regsOut[127:96]), CHECK_EN ? 256'h0 : 256'hAAAA5555);
        checkOutput("paddr change reg2", 256'(regsOut[95:64]), 256'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        checkOutput("prot_err sticky", 256'(protErr), 256'(CHECK_EN));
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        checkOutput("prot_err cleared 1", 256'(protErr), 256'h0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, BASE + 32'h08, 32'h12345678);
        checkOutput("no-setup PSLVERR", 256'(pslverr), 256'h0);
        checkOutput("no-setup PRDATA", 256'(prdata), 256'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        checkOutput("no-setup prot_err", 256'(protErr), 256'(CHECK_EN));
        checkOutput("no-setup wr_pulse", 256'(wrPulse), 256'h0);
        checkOutput("no-setup reg2", 256'(regsOut[95:64]), 256'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        checkOutput("prot_err cleared 2", 256'(protErr), 256'h0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, BASE, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, BASE, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        checkOutput("psel drop prot_err", 256'(protErr), 256'(CHECK_EN));
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        checkOutput("prot_err cleared 3", 256'(protErr), 256'h0);
        checkOutput("final reset regs_out", regsOut, 256'h0);

        $display("[TB] randomized transfers");
        for (int i = 0; i < 8; i++) model[i] = 32'h0;
        expPulse = 8'h0;
        for (int t = 0; t < 200; t++) begin
            isWrite = 1'($urandom_range(0, 1));
            sel     = int'($urandom_range(0, 9));
            if (sel < 6)       addr = BASE + 32'($urandom_range(0, 7) << 2);
            else if (sel < 8)  addr = BASE + 32'($urandom_range(0, 31));
            else if (sel == 8) addr = BASE + 32'h20 + 32'($urandom_range(0, 15) << 2);
            else               addr = BASE - 32'($urandom_range(1, 4) << 2);
            data     = $urandom;
            statusIn = $urandom;

            applyStimulus(1'b1, 1'b1, 1'b0, isWrite, addr, data);
            checkOutput($sformatf("rnd%0d setup wr_pulse", t), 256'(wrPulse), 256'(expPulse));
            checkOutput($sformatf("rnd%0d setup regs", t), regsOut, packModel());
            checkOutput($sformatf("rnd%0d setup PRDATA", t), 256'(prdata), 256'h0);
            expPulse = 8'h0;

            off     = addr - BASE;
            hit     = (off < 32'd32);
            idx     = int'(off >> 2);
            aligned = (addr[1:0] == 2'b00);
            expRd   = 32'h0;
            if (hit && !isWrite && aligned) expRd = (idx == 7) ? statusIn : model[idx];
            expErr  = hit && (!aligned || (isWrite && idx == 7));

            applyStimulus(1'b1, 1'b1, 1'b1, isWrite, addr, data);
            checkOutput($sformatf("rnd%0d PRDATA addr=%0h", t, addr), 256'(prdata), 256'(expRd));
            checkOutput($sformatf("rnd%0d PSLVERR addr=%0h", t, addr), 256'(pslverr), 256'(expErr));
            if (hit && isWrite && aligned && idx != 7) begin
                model[idx] = data;
                expPulse   = 8'(1 << idx);
            end

            if ($urandom_range(0, 1) == 1) begin
                applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
                checkOutput($sformatf("rnd%0d idle wr_pulse", t), 256'(wrPulse), 256'(expPulse));
                checkOutput($sformatf("rnd%0d idle regs", t), regsOut, packModel());
                expPulse = 8'h0;
            end
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        checkOutput("rnd end wr_pulse", 256'(wrPulse), 256'(expPulse));
        checkOutput("rnd end regs", regsOut, packModel());
        checkOutput("rnd end prot_err", 256'(protErr), 256'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
